haze_synth_pipe: RTL
====================

# haze_synth_pipe

Pipelined per-pixel haze synthesis block: the forward atmospheric-scattering model that the recovery path inverts. Given a clear pixel J (RGB), atmospheric light A (RGB) and transmission t (Q0.8), it produces the hazy pixel I = A + t·(J − A) per channel. It sits on the verification/test-pattern path and generates hazy frames from clean frames so the dehaze pipeline can be closed-loop checked on FPGA. It is a 3-stage valid/ready pipeline with a frame pixel counter and an end-of-frame pulse.

## Interface
- IMG_WIDTH, 512, pixels per line
- IMG_HEIGHT, 512, lines per frame
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input pixel qualifier
- in_ready  output  1  block can accept a pixel this cycle
- J_R, J_G, J_B  input  8 each  clear pixel channels
- A_R, A_G, A_B  input  8 each  atmospheric light channels
- t  input  8  transmission, Q0.8 (0 = full haze, 255 ≈ 1.0)
- out_valid  output  1  output pixel qualifier
- out_ready  input  1  downstream accepts output this cycle
- I_R, I_G, I_B  output  8 each  hazy pixel channels
- frame_done  output  1  one-cycle pulse when the last pixel of a frame is accepted downstream

## Operation
- Transfer occurs on a side when valid && ready are both high at the rising edge.
- Per channel c, arithmetic:
  - S1: ge = (J_c ≥ A_c); mag = ge ? J_c − A_c : A_c − J_c (8-bit, 0..255); A_c and ge registered alongside.
  - S2: prod = mag × t, 16-bit unsigned.
  - S3: scaled = (prod + 128) >> 8, 8-bit; I_c = ge ? A_c + scaled : A_c − scaled.
- scaled ≤ mag always, so I_c lies in [min(A_c,J_c), max(A_c,J_c)]; no wrap. The adder still clamps to 0..255 as a guard.
- t = 0 → I_c = A_c exactly. J_c = A_c → I_c = A_c for any t.
- Pipeline stalls as a unit: advance = !s3_valid || out_ready; in_ready = advance. While advance is low, all stage registers and valid bits hold.
- Stage valid bits propagate with data; bubbles are allowed (in_valid low inserts an invalid slot).
- Pixel counter: col counts 0..IMG_WIDTH−1 on each output transfer, row increments on col wrap. On the transfer with col = IMG_WIDTH−1 and row = IMG_HEIGHT−1, both wrap to 0 and frame_done pulses the following cycle.
- Counters advance only on output transfers (out_valid && out_ready), never on stalls or bubbles.

## Timing
- Latency: 3 cycles from input transfer to out_valid with no backpressure; throughput 1 pixel/cycle.
- Reset values: out_valid = 0, frame_done = 0, I_R/I_G/I_B = 0, all stage valid bits 0, col = row = 0. in_ready = 1 during and after reset (pipeline empty).
- Reset mid-frame: all in-flight pixels are discarded, counters return to 0, and there is no frame_done pulse. The next accepted pixel is pixel (0,0).
- Output data stays stable while out_valid && !out_ready (AXI-stream rule); out_valid never drops without a transfer.
- Simultaneous input and output transfer with a full pipeline: allowed, no bubble inserted.
- frame_done is registered, one cycle wide, and asserted the cycle after the final transfer, regardless of out_ready in that cycle.

## Test plan
- J=(200,50,100), A=(100,200,100), t=128 -> I=(150,125,100) after 3 cycles. Derivation: G: 150·128 = 19200, +128 → 75, 200 − 75 = 125.
- J=(50,255,0), A=(200,0,0), t=64 / t=255 / t=0 -> t=64: R=200−38=162; t=255: G=254; t=0: I=A for all channels.
- Continuous stream of 16 random pixels with out_ready tied high -> out_valid high for 16 consecutive cycles starting at cycle 3; outputs match the reference model bit-exactly.
- out_ready toggled with a random 50% pattern -> no pixel lost or duplicated; output held stable while stalled; in_ready low exactly when s3 is full and out_ready is low.
- IMG_WIDTH=4, IMG_HEIGHT=2, 8 pixels streamed twice -> frame_done pulses exactly twice, each one cycle after the 8th output transfer.
- rst asserted for 1 cycle with 2 pixels in flight at pixel index 5 -> out_valid=0 the next cycle, no frame_done pulse; the following 8 pixels produce frame_done after the 8th.

Source files
------------

// File: rtl/haze_synth_pipe.sv
// Forward haze model I = A + t*(J - A) per RGB channel, as a 3-stage valid/ready
// pipeline that stalls as a unit, with a frame pixel counter and end-of-frame pulse.
module haze_synth_pipe #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] J_R,
  input  logic [7:0] J_G,
  input  logic [7:0] J_B,
  input  logic [7:0] A_R,
  input  logic [7:0] A_G,
  input  logic [7:0] A_B,
  input  logic [7:0] t,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] I_R,
  output logic [7:0] I_G,
  output logic [7:0] I_B,
  output logic       frame_done
);
  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic       advance;
  logic       s1_valid_q, s1_valid_d;
  logic       s2_valid_q, s2_valid_d;
  logic       s3_valid_q, s3_valid_d;
  logic [7:0] s1_t_q, s1_t_d;
  logic [7:0] j_ch [3];
  logic [7:0] a_ch [3];
  logic [7:0] i_ch [3];

  assign j_ch[0] = J_R;
  assign j_ch[1] = J_G;
  assign j_ch[2] = J_B;
  assign a_ch[0] = A_R;
  assign a_ch[1] = A_G;
  assign a_ch[2] = A_B;

  assign advance   = !s3_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = s3_valid_q;
  assign I_R       = i_ch[0];
  assign I_G       = i_ch[1];
  assign I_B       = i_ch[2];

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    s3_valid_d = s3_valid_q;
    s1_t_d     = s1_t_q;
    if (advance) begin
      s1_valid_d = in_valid;
      s2_valid_d = s1_valid_q;
      s3_valid_d = s2_valid_q;
      s1_t_d     = t;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s1_t_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s3_valid_q <= s3_valid_d;
      s1_t_q     <= s1_t_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      logic        s1_ge_q, s1_ge_d, s2_ge_q, s2_ge_d;
      logic [7:0]  s1_mag_q, s1_mag_d;
      logic [7:0]  s1_a_q, s1_a_d, s2_a_q, s2_a_d;
      logic [15:0] s2_prod_q, s2_prod_d;
      logic [7:0]  s3_i_q, s3_i_d;
      logic [16:0] rounded;
      logic [8:0]  scaled;
      logic [9:0]  sum;
      logic [7:0]  result;

      always_comb begin
        s1_ge_d   = s1_ge_q;
        s1_mag_d  = s1_mag_q;
        s1_a_d    = s1_a_q;
        s2_ge_d   = s2_ge_q;
        s2_a_d    = s2_a_q;
        s2_prod_d = s2_prod_q;
        s3_i_d    = s3_i_q;

        rounded = {1'b0, s2_prod_q} + 17'd128;
        scaled  = 9'(rounded >> 8);
        // Ten bits so an overshoot above 255 or a borrow below 0 is visible for clamping.
        if (s2_ge_q) begin
          sum    = {2'b00, s2_a_q} + {1'b0, scaled};
          result = sum[8] ? 8'hff : sum[7:0];
        end else begin
          sum    = {2'b00, s2_a_q} - {1'b0, scaled};
          result = sum[9] ? 8'h00 : sum[7:0];
        end

        if (advance) begin
          s1_ge_d   = (j_ch[gi] >= a_ch[gi]);
          s1_mag_d  = (j_ch[gi] >= a_ch[gi]) ? (j_ch[gi] - a_ch[gi]) : (a_ch[gi] - j_ch[gi]);
          s1_a_d    = a_ch[gi];
          s2_ge_d   = s1_ge_q;
          s2_a_d    = s1_a_q;
          s2_prod_d = {8'h00, s1_mag_q} * {8'h00, s1_t_q};
          s3_i_d    = result;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_ge_q   <= 1'b0;
          s1_mag_q  <= '0;
          s1_a_q    <= '0;
          s2_ge_q   <= 1'b0;
          s2_a_q    <= '0;
          s2_prod_q <= '0;
          s3_i_q    <= '0;
        end else begin
          s1_ge_q   <= s1_ge_d;
          s1_mag_q  <= s1_mag_d;
          s1_a_q    <= s1_a_d;
          s2_ge_q   <= s2_ge_d;
          s2_a_q    <= s2_a_d;
          s2_prod_q <= s2_prod_d;
          s3_i_q    <= s3_i_d;
        end
      end

      assign i_ch[gi] = s3_i_q;
    end
  endgenerate

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             frame_done_q, frame_done_d;

  // Position tracks pixels actually handed downstream, so stalls and bubbles never move it.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = 1'b0;
    if (s3_valid_q && out_ready) begin
      if (col_q == COL_W'(IMG_WIDTH - 1)) begin
        col_d = '0;
        if (row_q == ROW_W'(IMG_HEIGHT - 1)) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_done = frame_done_q;
endmodule
